// File: rtl/pixel_write_arbiter_pkg.sv
// Shared types and constants for the pixel write arbiter: coordinate/color widths,
// screen bounds, grant encoding and the packed FIFO entry.
package pixel_write_arbiter_pkg;

  localparam int unsigned nX          = 10;
  localparam int unsigned nY          = 9;
  localparam int unsigned COLOR_DEPTH = 9;
  localparam int unsigned PIX_W       = nX + nY + COLOR_DEPTH;

  localparam logic [nX-1:0] XSCREEN = 10'd640;
  localparam logic [nY-1:0] YSCREEN = 9'd480;

  typedef enum logic {
    GrantPlayer = 1'b0,
    GrantObst   = 1'b1
  } grant_e;

  typedef struct packed {
    logic [nX-1:0]          x;
    logic [nY-1:0]          y;
    logic [COLOR_DEPTH-1:0] color;
  } pixel_t;

  function automatic pixel_t pack_pixel(input logic [nX-1:0]          x,
                                        input logic [nY-1:0]          y,
                                        input logic [COLOR_DEPTH-1:0] color);
    pixel_t p;
    p.x     = x;
    p.y     = y;
    p.color = color;
    return p;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock synchronous FIFO with combinational read data (head of queue),
// power-of-two depth, wrapping pointers and an explicit occupancy count.
module pixel_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Merges player and obstacle pixel writes into one VGA write port via per-source FIFOs
// and round-robin arbitration with player override. Optional PIXEL_CLIP_EN drops
// off-screen pixels at push time.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [nX-1:0]          p_x,
  input  logic [nY-1:0]          p_y,
  input  logic [COLOR_DEPTH-1:0] p_color,
  input  logic                   p_write,
  input  logic                   p_priority,
  input  logic [nX-1:0]          o_x,
  input  logic [nY-1:0]          o_y,
  input  logic [COLOR_DEPTH-1:0] o_color,
  input  logic                   o_write,
  output logic [nX-1:0]          VGA_x,
  output logic [nY-1:0]          VGA_y,
  output logic [COLOR_DEPTH-1:0] VGA_color,
  output logic                   VGA_write,
  output logic                   p_full,
  output logic                   o_full,
  output logic                   p_overflow,
  output logic                   o_overflow,
  input  logic                   clear_overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [PIX_W-1:0] p_rdata, o_rdata;
  logic [CntW-1:0]  p_count, o_count;
  logic             p_fifo_full, o_fifo_full;
  logic             p_empty, o_empty;
  logic             p_in_range, o_in_range;
  logic             p_req, o_req, p_push, o_push, p_pop, o_pop;

  logic   grant_valid;
  grant_e grant_sel;

  grant_e last_grant_q, last_grant_d;
  pixel_t vga_pix_q, vga_pix_d;
  logic   vga_write_q, vga_write_d;
  logic   p_ovf_q, p_ovf_d, o_ovf_q, o_ovf_d;

`ifdef PIXEL_CLIP_EN
  assign p_in_range = (p_x < XSCREEN) && (p_y < YSCREEN);
  assign o_in_range = (o_x < XSCREEN) && (o_y < YSCREEN);
`else
  assign p_in_range = 1'b1;
  assign o_in_range = 1'b1;
`endif

  // Clipped pixels never reach the FIFO, so they cannot count as drops.
  assign p_req  = p_write && p_in_range;
  assign o_req  = o_write && o_in_range;
  assign p_push = p_req && (!p_fifo_full || p_pop);
  assign o_push = o_req && (!o_fifo_full || o_pop);

  pixel_fifo #(
    .Width (PIX_W),
    .Depth (FIFO_DEPTH)
  ) u_p_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (p_push),
    .wdata_i (pack_pixel(p_x, p_y, p_color)),
    .pop_i   (p_pop),
    .rdata_o (p_rdata),
    .full_o  (p_fifo_full),
    .empty_o (p_empty),
    .count_o (p_count)
  );

  pixel_fifo #(
    .Width (PIX_W),
    .Depth (FIFO_DEPTH)
  ) u_o_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (o_push),
    .wdata_i (pack_pixel(o_x, o_y, o_color)),
    .pop_i   (o_pop),
    .rdata_o (o_rdata),
    .full_o  (o_fifo_full),
    .empty_o (o_empty),
    .count_o (o_count)
  );

  assign p_full = (p_count == CntW'(FIFO_DEPTH));
  assign o_full = (o_count == CntW'(FIFO_DEPTH));

  // Ties go to whoever did not win last, unless the player is in collision mode.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = GrantPlayer;
    if (!p_empty && !o_empty) begin
      grant_valid = 1'b1;
      if (p_priority) grant_sel = GrantPlayer;
      else            grant_sel = (last_grant_q == GrantPlayer) ? GrantObst : GrantPlayer;
    end else if (!p_empty) begin
      grant_valid = 1'b1;
      grant_sel   = GrantPlayer;
    end else if (!o_empty) begin
      grant_valid = 1'b1;
      grant_sel   = GrantObst;
    end
  end

  assign p_pop = grant_valid && (grant_sel == GrantPlayer);
  assign o_pop = grant_valid && (grant_sel == GrantObst);

  always_comb begin
    vga_pix_d    = vga_pix_q;
    vga_write_d  = grant_valid;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      vga_pix_d    = (grant_sel == GrantPlayer) ? pixel_t'(p_rdata) : pixel_t'(o_rdata);
      last_grant_d = grant_sel;
    end
    // A drop in the clearing cycle keeps the flag set.
    p_ovf_d = p_ovf_q;
    o_ovf_d = o_ovf_q;
    if (clear_overflow) begin
      p_ovf_d = 1'b0;
      o_ovf_d = 1'b0;
    end
    if (p_req && !p_push) p_ovf_d = 1'b1;
    if (o_req && !o_push) o_ovf_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vga_pix_q    <= '0;
      vga_write_q  <= 1'b0;
      last_grant_q <= GrantObst;
      p_ovf_q      <= 1'b0;
      o_ovf_q      <= 1'b0;
    end else begin
      vga_pix_q    <= vga_pix_d;
      vga_write_q  <= vga_write_d;
      last_grant_q <= last_grant_d;
      p_ovf_q      <= p_ovf_d;
      o_ovf_q      <= o_ovf_d;
    end
  end

  assign VGA_x      = vga_pix_q.x;
  assign VGA_y      = vga_pix_q.y;
  assign VGA_color  = vga_pix_q.color;
  assign VGA_write  = vga_write_q;
  assign p_overflow = p_ovf_q;
  assign o_overflow = o_ovf_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_pixel_write_arbiter;
  import pixel_write_arbiter_pkg::*;

  localparam int Depth = 16;

  logic                   Clock = 1'b0;
  logic                   Reset;
  logic [nX-1:0]          p_x, o_x;
  logic [nY-1:0]          p_y, o_y;
  logic [COLOR_DEPTH-1:0] p_color, o_color;
  logic                   p_write, o_write, p_priority, clear_overflow;
  logic [nX-1:0]          VGA_x;
  logic [nY-1:0]          VGA_y;
  logic [COLOR_DEPTH-1:0] VGA_color;
  logic                   VGA_write, p_full, o_full, p_overflow, o_overflow;

  pixel_write_arbiter #(.FIFO_DEPTH(Depth)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .p_x            (p_x),
    .p_y            (p_y),
    .p_color        (p_color),
    .p_write        (p_write),
    .p_priority     (p_priority),
    .o_x            (o_x),
    .o_y            (o_y),
    .o_color        (o_color),
    .o_write        (o_write),
    .VGA_x          (VGA_x),
    .VGA_y          (VGA_y),
    .VGA_color      (VGA_color),
    .VGA_write      (VGA_write),
    .p_full         (p_full),
    .o_full         (o_full),
    .p_overflow     (p_overflow),
    .o_overflow     (o_overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: plain queues of pending pixels per source.
  pixel_t pq[$];
  pixel_t oq[$];
  bit     m_last_obst = 1'b1;
  bit     m_vw = 1'b0;
  pixel_t m_vpix = '0;
  bit     m_povf = 1'b0, m_oovf = 1'b0;
  int     m_accepted = 0;
  pixel_t out_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit on_screen(input logic [nX-1:0] x, input logic [nY-1:0] y);
`ifdef PIXEL_CLIP_EN
    return (int'(x) < 640) && (int'(y) < 480);
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    bit go, to_player;
    @(posedge Clock);
    if (Reset) begin
      pq.delete();
      oq.delete();
      m_vw = 0;
      m_vpix = '0;
      m_povf = 0;
      m_oovf = 0;
      m_last_obst = 1;
    end else begin
      go = 0;
      to_player = 0;
      if (pq.size() > 0 && oq.size() > 0) begin
        go = 1;
        to_player = p_priority ? 1'b1 : m_last_obst;
      end else if (pq.size() > 0) begin
        go = 1;
        to_player = 1;
      end else if (oq.size() > 0) begin
        go = 1;
        to_player = 0;
      end
      m_vw = go;
      if (go) begin
        if (to_player) m_vpix = pq.pop_front();
        else           m_vpix = oq.pop_front();
        m_last_obst = !to_player;
      end
      if (clear_overflow) begin
        m_povf = 0;
        m_oovf = 0;
      end
      if (p_write && on_screen(p_x, p_y)) begin
        if (pq.size() < Depth) begin
          pq.push_back(pack_pixel(p_x, p_y, p_color));
          m_accepted++;
        end else m_povf = 1;
      end
      if (o_write && on_screen(o_x, o_y)) begin
        if (oq.size() < Depth) begin
          oq.push_back(pack_pixel(o_x, o_y, o_color));
          m_accepted++;
        end else m_oovf = 1;
      end
    end
    #1;
    check("vga_write", 32'(VGA_write), 32'(m_vw));
    check("vga_pixel", 32'({VGA_x, VGA_y, VGA_color}), 32'(m_vpix));
    check("flags", 32'({p_full, o_full, p_overflow, o_overflow}),
          32'({pq.size() == Depth, oq.size() == Depth, m_povf, m_oovf}));
    if (VGA_write) out_log.push_back(pack_pixel(VGA_x, VGA_y, VGA_color));
  endtask

  task automatic idle();
    p_write = 0;
    o_write = 0;
    clear_overflow = 0;
  endtask

  typedef struct {
    bit rst;
    bit pw; logic [9:0] px; logic [8:0] py; logic [8:0] pc;
    bit ow; logic [9:0] ox; logic [8:0] oy; logic [8:0] oc;
    bit ew; logic [9:0] ex; logic [8:0] ey; logic [8:0] ec;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int base;
    vecs[0] = '{1, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{0, 1, 130, 360, 'h3F, 0, 0, 0, 0,  0, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 0,      0, 0, 0, 0,  1, 130, 360, 'h3F};
    vecs[3] = '{0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 130, 360, 'h3F};
    vecs[4] = '{1, 0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0, 0};
    vecs[5] = '{0, 1, 1, 2, 3,      1, 4, 5, 6,  0, 0, 0, 0};
    vecs[6] = '{0, 0, 0, 0, 0,      0, 0, 0, 0,  1, 1, 2, 3};
    vecs[7] = '{0, 0, 0, 0, 0,      0, 0, 0, 0,  1, 4, 5, 6};
    vecs[8] = '{0, 0, 0, 0, 0,      0, 0, 0, 0,  0, 4, 5, 6};

    Reset = 1;
    p_priority = 0;
    p_x = 0; p_y = 0; p_color = 0;
    o_x = 0; o_y = 0; o_color = 0;
    idle();
    step();

    for (int i = 0; i < 9; i++) begin
      Reset = vecs[i].rst;
      p_write = vecs[i].pw; p_x = vecs[i].px; p_y = vecs[i].py; p_color = vecs[i].pc;
      o_write = vecs[i].ow; o_x = vecs[i].ox; o_y = vecs[i].oy; o_color = vecs[i].oc;
      step();
      check("vec_write", 32'(VGA_write), 32'(vecs[i].ew));
      check("vec_data", 32'({VGA_x, VGA_y, VGA_color}),
            32'({vecs[i].ex, vecs[i].ey, vecs[i].ec}));
    end
    idle();

    // Eight successive ties: each resolves player first, then obstacle.
    for (int t = 0; t < 8; t++) begin
      base = out_log.size();
      p_write = 1; p_x = 10'(100 + t); p_y = 9'(t); p_color = 9'h1C0;
      o_write = 1; o_x = 10'(200 + t); o_y = 9'(t); o_color = 9'h007;
      step();
      idle();
      step();
      step();
      check("tie_count", 32'(out_log.size() - base), 32'd2);
      if (out_log.size() - base == 2) begin
        check("tie_first", 32'(out_log[base].x), 32'(100 + t));
        check("tie_second", 32'(out_log[base + 1].x), 32'(200 + t));
      end
    end

    // Player in collision mode streams 60 pixels ahead of 10 queued obstacle pixels.
    Reset = 1; step(); Reset = 0;
    base = out_log.size();
    p_priority = 1;
    for (int i = 0; i < 60; i++) begin
      p_write = 1; p_x = 10'(i); p_y = 9'd7; p_color = 9'h1C0;
      o_write = (i < 10); o_x = 10'(500 + i); o_y = 9'd9; o_color = 9'h038;
      step();
    end
    idle();
    for (int i = 0; i < 15; i++) step();
    check("prio_count", 32'(out_log.size() - base), 32'd70);
    if (out_log.size() - base == 70) begin
      for (int i = 0; i < 70; i++)
        check("prio_order", 32'(out_log[base + i].x), (i < 60) ? 32'(i) : 32'(500 + i - 60));
    end
    check("prio_no_ovf", 32'({p_overflow, o_overflow}), 32'd0);
    p_priority = 0;

    // Both sources saturate: overflow must set, every accepted pixel still drains.
    Reset = 1; step(); Reset = 0;
    base = out_log.size();
    m_accepted = 0;
    for (int i = 0; i < 40; i++) begin
      p_write = 1; p_x = 10'($urandom_range(0, 639)); p_y = 9'($urandom_range(0, 479));
      p_color = 9'($urandom);
      o_write = 1; o_x = 10'($urandom_range(0, 639)); o_y = 9'($urandom_range(0, 479));
      o_color = 9'($urandom);
      step();
    end
    idle();
    check("sat_ovf_set", 32'(p_overflow | o_overflow), 32'd1);
    for (int i = 0; i < 40; i++) step();
    check("sat_drained", 32'(out_log.size() - base), 32'(m_accepted));
    clear_overflow = 1; step(); clear_overflow = 0;
    check("sat_ovf_clr", 32'({p_overflow, o_overflow}), 32'd0);

    // Reset with a backlog: nothing pending may survive.
    for (int i = 0; i < 8; i++) begin
      p_write = 1; p_x = 10'(i); o_write = 1; o_x = 10'(300 + i);
      step();
    end
    idle();
    Reset = 1; step(); Reset = 0;
    check("rst_write_low", 32'(VGA_write), 32'd0);
    base = out_log.size();
    for (int i = 0; i < 20; i++) step();
    check("rst_no_stale", 32'(out_log.size() - base), 32'd0);

`ifdef PIXEL_CLIP_EN
    base = out_log.size();
    p_write = 1; p_x = 10'd700; p_y = 9'd10; step();
    p_x = 10'd5; p_y = 9'd480; step();
    idle();
    for (int i = 0; i < 3; i++) step();
    check("clip_dropped", 32'(out_log.size() - base), 32'd0);
    check("clip_no_ovf", 32'({p_overflow, o_overflow}), 32'd0);
    p_write = 1; p_x = 10'd639; p_y = 9'd479; p_color = 9'h155; step();
    idle();
    step(); step();
    check("clip_edge_cnt", 32'(out_log.size() - base), 32'd1);
    if (out_log.size() - base == 1)
      check("clip_edge_xy", 32'({out_log[base].x, out_log[base].y}), {13'd0, 10'd639, 9'd479});
`endif

    // Randomized traffic, including off-screen coordinates and sporadic resets.
    for (int i = 0; i < 1500; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) p_priority = ~p_priority;
      clear_overflow = ($urandom_range(0, 15) == 0);
      p_write = ($urandom_range(0, 3) != 0);
      o_write = ($urandom_range(0, 2) != 0);
      p_x = 10'($urandom); p_y = 9'($urandom); p_color = 9'($urandom);
      o_x = 10'($urandom); o_y = 9'($urandom); o_color = 9'($urandom);
      step();
    end
    Reset = 0;
    idle();
    for (int i = 0; i < 40; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
- Sink end of the pixel-write interface used by the drawing FSMs (x, y, color, write strobe).
- Merges pixel writes from the player drawer and the obstacle drawer into the single VGA adapter write port.
- Source writes have no backpressure, so each source is buffered in its own FIFO.
- Arbitration is round-robin, except that the player gets strict priority while its collision/priority flag is high. This keeps the red player on top of obstacles.

Parameters:
- nX, 10, x coordinate width (640 px)
- nY, 9, y coordinate width (480 px)
- COLOR_DEPTH, 9, pixel color width (3/3/3 RGB)
- FIFO_DEPTH, 16, entries per source FIFO (power of two)
- XSCREEN, 640, screen width (used by clip option)
- YSCREEN, 480, screen height (used by clip option)

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high reset
- p_x  in  nX  player pixel x
- p_y  in  nY  player pixel y
- p_color  in  COLOR_DEPTH  player pixel color
- p_write  in  1  player write strobe, one pixel per cycle
- p_priority  in  1  player collision mode; level-sensitive, gives player strict priority
- o_x  in  nX  obstacle pixel x
- o_y  in  nY  obstacle pixel y
- o_color  in  COLOR_DEPTH  obstacle pixel color
- o_write  in  1  obstacle write strobe
- VGA_x  out  nX  merged pixel x to VGA adapter
- VGA_y  out  nY  merged pixel y
- VGA_color  out  COLOR_DEPTH  merged pixel color
- VGA_write  out  1  merged write strobe
- p_full  out  1  player FIFO full (combinational from count)
- o_full  out  1  obstacle FIFO full
- p_overflow  out  1  sticky: player pixel dropped
- o_overflow  out  1  sticky: obstacle pixel dropped
- clear_overflow  in  1  clears both sticky flags

Behaviour:
- Reset (synchronous, high):
  - both FIFOs empty; VGA_x/VGA_y/VGA_color = 0; VGA_write = 0
  - p_overflow = o_overflow = 0; last_grant = OBST, so the player wins the first tie.
- Push rules:
  - On a rising edge with x_write = 1, the entry {x, y, color} is pushed if the FIFO is not full, or if it is full and popped in the same cycle.
  - Otherwise the entry is dropped and x_overflow sets. It stays set until clear_overflow or Reset.
  - If clear_overflow and a new drop occur in the same cycle, the flag remains set.
- Arbitration runs every cycle on the FIFO states registered at the previous edge:
  - p_priority = 1 and player FIFO non-empty: grant PLAYER.
  - p_priority = 1 and player FIFO empty: grant OBST if it is non-empty.
  - p_priority = 0 and both non-empty: grant the source that is not last_grant.
  - Only one non-empty: grant it.
  - Neither non-empty: no grant.
- On a grant:
  - pop that FIFO and load VGA_x/VGA_y/VGA_color at the edge with VGA_write = 1
  - update last_grant.
- With no grant, VGA_write = 0 and VGA_x/VGA_y/VGA_color hold their last values.
- Latency: a pixel strobed in cycle N appears on VGA_* in cycle N+2 when its FIFO was empty and it wins arbitration. There is no bypass path.
- Throughput: at most one output pixel per cycle.
  - Both sources writing continuously overflow after roughly 2*FIFO_DEPTH cycles.
  - Per-source order is preserved; cross-source order is not.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-burst: both FIFOs are flushed; pending pixels are lost; VGA_write = 0 on the next cycle.

Optional Feature:
- PIXEL_CLIP_EN
  - Defined: at push, entries with x >= XSCREEN or y >= YSCREEN are discarded silently. They never enter the FIFO and do not set overflow.
  - Undefined: all coordinates are accepted and forwarded unchanged.

Decomposition:
- Shared package:
  - nX, nY, COLOR_DEPTH
  - XSCREEN, YSCREEN
  - grant encoding (GRANT_PLAYER = 1'b0, GRANT_OBST = 1'b1)
  - pixel entry packing/width constant (nX + nY + COLOR_DEPTH = 28)
- One natural sub-module: pixel_fifo.
  - Synchronous single-clock FIFO with push, pop, full, empty and count.
  - Instantiated twice; the arbiter logic and output register stay in the top.

Test Plan:
- Reset, then a single p_write of (x=130, y=360, color=9'h03F) in cycle 1 → VGA_write = 1 in cycle 3 with exactly those values; VGA_write = 0 in cycles 2 and 4.
- Both sources write one pixel each in the same cycle with p_priority = 0 → player pixel output first, obstacle next cycle; the next tie goes to player (alternation verified over 8 ties).
- p_priority = 1, player writes 60 pixels back-to-back while obstacle writes 10 → all 60 player pixels output before any obstacle pixel. Player FIFO never exceeds 1 entry; obstacle FIFO reaches 10, no overflow.
- Both sources write continuously for 40 cycles, FIFO_DEPTH = 16 → an overflow flag sets. Output count equals accepted count; clear_overflow with no new drops clears both flags.
- Reset asserted with 8 entries pending → VGA_write = 0 the following cycle; no stale pixel appears after Reset deasserts.
- PIXEL_CLIP_EN defined, p_write with x=700 or y=480 → no output and no overflow; x=639, y=479 is forwarded.
